sat_accumulator: RTL and testbench

Sequential saturating accumulator that sits directly upstream of, and instantiates, `sixteen_bit_adder`. It drives the adder's `a`, `b` and `cin` from an internal accumulator and an input stream, and consumes `result` and `overflow` to produce a clamped signed 16-bit running sum or difference. A transaction accepts `len` samples over a valid/ready handshake, then presents the final sum with a saturation flag until downstream takes it.

---
 rtl/alu_pkg.sv | 13 +
 rtl/sat_accumulator_if.sv | 29 ++
 rtl/sixteen_bit_adder.sv | 13 +
 rtl/sat_accumulator.sv | 85 ++++++++
 tb/tb_sat_accumulator.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the saturating accumulator datapath.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/sat_accumulator_if.sv
// Control, sample-stream and result signals of the saturating accumulator.
interface sat_accumulator_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
);

  logic             start;
  logic [CNT_W-1:0] len;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sat;
  logic             busy;

  modport master (
    output start, len, sub, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  start, len, sub, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, busy
  );

endinterface

// File: rtl/sixteen_bit_adder.sv
// 16-bit two's-complement adder with carry-in and signed-overflow flag.
module sixteen_bit_adder (
  input  logic        cin,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        overflow,
  output logic [15:0] result
);

  assign result   = a + b + {15'd0, cin};
  assign overflow = (a[15] == b[15]) && (result[15] != a[15]);

endmodule

// File: rtl/sat_accumulator.sv
// Saturating accumulator: sums or subtracts len samples through sixteen_bit_adder,
// clamping each step to the signed 16-bit range and flagging any saturation.
module sat_accumulator
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  sat_accumulator_if.slave  bus
);

  acc_state_t       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_remaining;
  logic             r_sat;
  logic             r_sub;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;

  // Subtraction as acc + ~x + 1 keeps a single adder in the path.
  assign w_b = r_sub ? ~bus.in_data : bus.in_data;

  sixteen_bit_adder u_adder (
    .cin      (r_sub),
    .a        (r_acc),
    .b        (w_b),
    .overflow (w_overflow),
    .result   (w_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_remaining <= '0;
      r_sat       <= 1'b0;
      r_sub       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_remaining <= bus.len;
            if (bus.len != '0) begin
              r_sub   <= bus.sub;
              r_state <= ACCUM;
            end else begin
              r_sub   <= 1'b0;
              r_state <= DONE;
            end
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            // Overflow only happens when acc and b agree in sign, so clamp toward acc's sign.
            if (w_overflow) begin
              r_acc <= r_acc[WIDTH-1] ? SAT_MIN : SAT_MAX;
              r_sat <= 1'b1;
            end else begin
              r_acc <= w_result;
            end
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) r_state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ACCUM);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == ACCUM) || (r_state == DONE);
  assign bus.out_data  = r_acc;
  assign bus.out_sat   = r_sat;

endmodule

// File: tb/tb_sat_accumulator.sv
// Directed bench for sat_accumulator with a scoreboard of expected results.
module tb_sat_accumulator;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   smp[$];
  exp_t exp_q[$];

  sat_accumulator_if #(.WIDTH(16), .CNT_W(8)) bus ();

  sat_accumulator #(.WIDTH(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic s, output logic [15:0] d, output logic st);
    int acc;
    acc = 0;
    st  = 1'b0;
    foreach (smp[i]) begin
      acc = s ? acc - smp[i] : acc + smp[i];
      if (acc > 32767) begin
        acc = 32767;
        st  = 1'b1;
      end else if (acc < -32768) begin
        acc = -32768;
        st  = 1'b1;
      end
    end
    d = 16'(acc);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string tag, input logic [7:0] n, input logic s,
                         input bit gap, input int hold);
    logic [15:0] ed;
    logic        es;
    exp_t        e;
    model(s, ed, es);
    e.d = ed;
    e.s = es;
    exp_q.push_back(e);

    bus.start = 1'b1; bus.len = n; bus.sub = s;
    step();
    bus.start = 1'b0; bus.len = '0; bus.sub = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);

    for (int i = 0; i < smp.size(); i++) begin
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(smp[i]);
      step();
      bus.in_valid = 1'b0;
      if (gap && i != smp.size() - 1) begin
        bus.start = 1'b1; bus.len = 8'd9;
        step();
        bus.start = 1'b0; bus.len = '0;
      end
    end

    chk({tag, "_valid_latency"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1234;
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_hold_data"}, 32'(bus.out_data), 32'(ed));
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      bus.start = (h == 1);
      bus.len   = 8'd3;
      step();
      bus.start = 1'b0;
      bus.len   = '0;
    end
    bus.in_valid = 1'b0;

    bus.out_ready = 1'b1;
    e = exp_q.pop_front();
    chk({tag, "_data"}, 32'(bus.out_data), 32'(e.d));
    chk({tag, "_sat"}, 32'(bus.out_sat), 32'(e.s));
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_valid_fall"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.sub = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_sat", 32'(bus.out_sat), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of accumulation discards the partial sum.
    bus.start = 1'b1; bus.len = 8'd4; bus.sub = 1'b0;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'd100;
    step();
    bus.in_data = 16'd200;
    step();
    bus.in_valid = 1'b0;
    chk("mid_partial", 32'(bus.out_data), 32'd300);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_sat", 32'(bus.out_sat), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    step();

    smp = '{15, 12, -19};          run_txn("add",      8'd3, 1'b0, 1'b0, 1);
    smp = '{32767, 32767, -5};     run_txn("pos_sat",  8'd3, 1'b0, 1'b0, 1);
    smp = '{1923, -32768};         run_txn("sub_mix",  8'd2, 1'b1, 1'b0, 1);
    smp = '{-32768};               run_txn("sub_min",  8'd1, 1'b1, 1'b0, 1);
    smp = '{1, -32768};            run_txn("sub_m1",   8'd2, 1'b1, 1'b0, 1);
    smp = '{32767, 2};             run_txn("neg_sat",  8'd2, 1'b1, 1'b0, 1);
    smp = '{1, 2, 3, 4};           run_txn("gap",      8'd4, 1'b0, 1'b1, 5);
    smp.delete();                  run_txn("len0",     8'd0, 1'b0, 1'b0, 3);
    smp = '{5};                    run_txn("after0",   8'd1, 1'b0, 1'b0, 1);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
